// File: rtl/controller_uart1_status_poller_if.sv
// ---------------------------------------------------------------------------
// controller_uart1_status_poller_if
//   Avalon-MM read-only bus between the UART1 status poller (master) and the
//   UART1 status PIO (slave s1).
//
//   avm_address      master -> slave  2   word address
//   avm_read         master -> slave  1   read request
//   avm_waitrequest  slave  -> master 1   slave stall
//   avm_readdata     slave  -> master 32  read data
// ---------------------------------------------------------------------------
interface controller_uart1_status_poller_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/controller_uart1_status_poller.sv
// ---------------------------------------------------------------------------
// controller_uart1_status_poller
//   Avalon-MM master that periodically reads the 10-bit UART1 status PIO,
//   keeps a shadow copy, and raises sticky W1C change events plus a level IRQ.
//
//   Optional feature macro: UART1_POLL_TIMEOUT_EN
//     defined   -> a read stalled by waitrequest for TIMEOUT_CYCLES cycles is
//                  dropped, timeout_err is set (sticky until reset) and the
//                  poller returns to its wait period without updating.
//     undefined -> reads wait indefinitely; timeout_err is tied low.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   enable         1 = polling active
//   poll_now       1-cycle pulse, starts a poll early while waiting
//   change_mask    per-bit enable for change events
//   event_clear    W1C strobe for event_bits
//   avm            Avalon-MM master port (address, read, waitrequest, readdata)
//   status         last sampled status
//   status_valid   a sample has been taken since reset/enable
//   event_bits     sticky change flags
//   irq            registered OR of event_bits
//   poll_count     completed polls, wraps at 16 bits
//   timeout_err    sticky stall-timeout flag
// ---------------------------------------------------------------------------
module controller_uart1_status_poller #(
  parameter int unsigned POLL_PERIOD    = 1000,
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [1:0]  STATUS_ADDR    = 2'd0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   poll_now,
  input  logic [9:0]                             change_mask,
  input  logic [9:0]                             event_clear,
  controller_uart1_status_poller_if.master       avm,
  output logic [9:0]                             status,
  output logic                                   status_valid,
  output logic [9:0]                             event_bits,
  output logic                                   irq,
  output logic [15:0]                            poll_count,
  output logic                                   timeout_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LAT   = 3'd2;
  localparam logic [2:0] ST_UPD   = 3'd3;
  localparam logic [2:0] ST_COUNT = 3'd4;

  localparam int unsigned TMR_W = $clog2(POLL_PERIOD + 1);
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  logic [2:0]       state_q,        state_d;
  logic [TMR_W-1:0] timer_q,        timer_d;
  logic [LAT_W-1:0] lat_cnt_q,      lat_cnt_d;
  logic [9:0]       rdata_q,        rdata_d;
  logic [9:0]       status_q,       status_d;
  logic             status_valid_q, status_valid_d;
  logic [9:0]       event_q,        event_d;
  logic             irq_q,          irq_d;
  logic [15:0]      count_q,        count_d;
  logic [9:0]       diff;

`ifdef UART1_POLL_TIMEOUT_EN
  localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Only the low 10 bits of the PIO word carry status.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^avm.avm_readdata[31:10];

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    lat_cnt_d      = lat_cnt_q;
    rdata_d        = rdata_q;
    status_d       = status_q;
    status_valid_d = status_valid_q;
    count_d        = count_q;
    diff           = '0;
`ifdef UART1_POLL_TIMEOUT_EN
    stall_d        = '0;
    timeout_err_d  = timeout_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (!avm.avm_waitrequest) begin
          state_d   = ST_LAT;
          lat_cnt_d = LAT_LOAD;
        end
`ifdef UART1_POLL_TIMEOUT_EN
        else if (stall_q == STALL_LAST) begin
          state_d       = ST_COUNT;
          timer_d       = TMR_LOAD;
          timeout_err_d = 1'b1;
        end else begin
          stall_d = stall_q + STALL_ONE;
        end
`endif
      end

      ST_LAT: begin
        if (lat_cnt_q == '0) begin
          rdata_d = avm.avm_readdata[9:0];
          state_d = ST_UPD;
          // Timer starts during UPD so that UPD-to-READ spacing equals
          // POLL_PERIOD cycles.
          timer_d = TMR_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_ONE;
        end
      end

      ST_UPD: begin
        diff           = status_valid_q ? ((rdata_q ^ status_q) & change_mask) : '0;
        status_d       = rdata_q;
        status_valid_d = 1'b1;
        count_d        = count_q + 16'd1;
        timer_d        = timer_q - TMR_ONE;
        state_d        = enable ? ST_COUNT : ST_IDLE;
      end

      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0 || poll_now) begin
          state_d = ST_READ;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Re-entering IDLE invalidates the shadow copy even on the UPD cycle.
    if (state_d == ST_IDLE) begin
      status_valid_d = 1'b0;
    end

    // New changes are OR-ed in after the clear, so a set wins.
    event_d = (event_q & ~event_clear) | diff;
    irq_d   = |event_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      lat_cnt_q      <= '0;
      rdata_q        <= '0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      event_q        <= '0;
      irq_q          <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lat_cnt_q      <= lat_cnt_d;
      rdata_q        <= rdata_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      event_q        <= event_d;
      irq_q          <= irq_d;
      count_q        <= count_d;
    end
  end

`ifdef UART1_POLL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_err        = 1'b0;
`endif

  assign avm.avm_address = STATUS_ADDR;
  assign avm.avm_read    = (state_q == ST_READ);

  assign status       = status_q;
  assign status_valid = status_valid_q;
  assign event_bits   = event_q;
  assign irq          = irq_q;
  assign poll_count   = count_q;

endmodule

// File: tb/tb_controller_uart1_status_poller.sv
// ---------------------------------------------------------------------------
// tb_controller_uart1_status_poller
//   Directed bench for controller_uart1_status_poller with a latency-2 slave
//   model. The slave drives valid data only in the cycle READ_LATENCY after
//   acceptance (inverted data otherwise), and queues the value it returned so
//   each completed poll can be checked against it.
// ---------------------------------------------------------------------------
module tb_controller_uart1_status_poller;

  localparam int unsigned POLL_PERIOD = 8;
`ifdef UART1_POLL_TIMEOUT_EN
  localparam int STALLS = 3;
`else
  localparam int STALLS = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        poll_now;
  logic [9:0]  change_mask;
  logic [9:0]  event_clear;
  logic [9:0]  status;
  logic        status_valid;
  logic [9:0]  event_bits;
  logic        irq;
  logic [15:0] poll_count;
  logic        timeout_err;

  logic        wr;
  logic [9:0]  slave_val;
  logic [1:0]  acc_pipe;

  int n_vec = 0;
  int n_bad = 0;

  logic [9:0]  exp_q[$];
  logic [15:0] last_cnt = '0;

  controller_uart1_status_poller_if bus ();

  controller_uart1_status_poller #(
    .POLL_PERIOD   (POLL_PERIOD),
    .READ_LATENCY  (2),
    .STATUS_ADDR   (2'd0),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .poll_now    (poll_now),
    .change_mask (change_mask),
    .event_clear (event_clear),
    .avm         (bus.master),
    .status      (status),
    .status_valid(status_valid),
    .event_bits  (event_bits),
    .irq         (irq),
    .poll_count  (poll_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Slave model: read data is valid exactly 2 cycles after acceptance.
  always @(posedge clk) begin
    if (reset) acc_pipe <= '0;
    else       acc_pipe <= {acc_pipe[0], bus.avm_read & ~bus.avm_waitrequest};
  end

  assign bus.avm_waitrequest = wr;
  assign bus.avm_readdata    = acc_pipe[1] ? {22'h2AAAAA, slave_val}
                                           : {22'h155555, ~slave_val};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_poll(input string tag);
    logic [15:0] c0;
    int k;
    c0 = poll_count;
    k  = 0;
    while (poll_count === c0 && k < 200) begin
      tick(1);
      k++;
    end
    chk({tag, "_done"}, 32'(poll_count !== c0), 32'd1);
  endtask

  task automatic wait_read(input string tag);
    int k;
    k = 0;
    while (bus.avm_read !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk({tag, "_read_seen"}, 32'(bus.avm_read), 32'd1);
  endtask

  // Scoreboard: push the value the slave returns, pop when a poll completes.
  always @(negedge clk) begin
    if (acc_pipe[1] === 1'b1) exp_q.push_back(slave_val);
    if (!$isunknown(poll_count) && poll_count !== last_cnt) begin
      if (poll_count == 16'd0) begin
        exp_q.delete();
      end else begin
        chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_status", 32'(status), 32'(exp_q.pop_front()));
      end
      last_cnt = poll_count;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd;
    int k;
    logic [15:0] c0;

    reset = 1'b1; enable = 1'b0; poll_now = 1'b0;
    change_mask = '0; event_clear = '0; wr = 1'b0; slave_val = 10'h0A5;
    tick(3);

    // Reset in the middle of a stalled read.
    reset = 1'b0; enable = 1'b1; wr = 1'b1;
    tick(1);
    chk("t1_read_before_reset", 32'(bus.avm_read), 32'd1);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("t1_read_dropped", 32'(bus.avm_read), 32'd0);
    chk("t1_status", 32'(status), 32'd0);
    chk("t1_status_valid", 32'(status_valid), 32'd0);
    chk("t1_event_bits", 32'(event_bits), 32'd0);
    chk("t1_irq", 32'(irq), 32'd0);
    chk("t1_poll_count", 32'(poll_count), 32'd0);
    chk("t1_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0; wr = 1'b0;
    tick(1);
    chk("t1_first_read_immediate", 32'(bus.avm_read), 32'd1);
    chk("t1_address", 32'(bus.avm_address), 32'd0);

    // First sample, then poll spacing.
    wait_poll("t2");
    chk("t2_status", 32'(status), 32'h0A5);
    chk("t2_status_valid", 32'(status_valid), 32'd1);
    chk("t2_event_bits", 32'(event_bits), 32'd0);
    chk("t2_poll_count", 32'(poll_count), 32'd1);
    slave_val = 10'h0A4; change_mask = 10'h3FF;
    k = 0;
    while (bus.avm_read !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("t2_spacing", 32'(k + 1), 32'(POLL_PERIOD));

    // Single-bit change, irq lag, W1C clear.
    wait_poll("t3");
    chk("t3_event_bits", 32'(event_bits), 32'h001);
    chk("t3_irq_lag", 32'(irq), 32'd0);
    tick(1);
    chk("t3_irq_set", 32'(irq), 32'd1);
    event_clear = 10'h001;
    tick(1);
    event_clear = '0;
    chk("t3_event_cleared", 32'(event_bits), 32'd0);
    chk("t3_irq_still_high", 32'(irq), 32'd1);
    tick(1);
    chk("t3_irq_cleared", 32'(irq), 32'd0);

    // Masking and set-wins-over-clear.
    change_mask = 10'h200; slave_val = 10'h2A5;
    wait_poll("t4a");
    chk("t4_masked_event", 32'(event_bits), 32'h200);
    slave_val = 10'h0A5;
    k = 0;
    while (acc_pipe[1] !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("t4_capture_seen", 32'(acc_pipe[1]), 32'd1);
    tick(1);
    c0 = poll_count;
    event_clear = 10'h200;
    tick(1);
    event_clear = '0;
    chk("t4_clear_aligned_upd", 32'(poll_count), 32'(c0 + 16'd1));
    chk("t4_set_wins", 32'(event_bits), 32'h200);
    event_clear = 10'h200;
    tick(1);
    event_clear = '0;
    chk("t4_plain_clear", 32'(event_bits), 32'd0);
    tick(1);
    chk("t4_irq_low", 32'(irq), 32'd0);

    // poll_now during COUNT, stalled read, latency-2 capture.
    slave_val = 10'h155; wr = 1'b1; poll_now = 1'b1;
    tick(1);
    poll_now = 1'b0;
    chk("t5_poll_now_read", 32'(bus.avm_read), 32'd1);
    rd = 0;
    while (bus.avm_read === 1'b1 && rd < 20) begin
      rd++;
      if (rd == STALLS + 1) wr = 1'b0;
      tick(1);
    end
    chk("t5_read_hold", 32'(rd), 32'(STALLS + 1));
    wait_poll("t5");
    chk("t5_status", 32'(status), 32'h155);

    // Stuck waitrequest.
    wr = 1'b1; slave_val = 10'h3C3; c0 = poll_count;
    wait_read("t6");
    rd = 0;
    while (bus.avm_read === 1'b1 && rd < 20) begin
      rd++;
      tick(1);
    end
`ifdef UART1_POLL_TIMEOUT_EN
    chk("t6_read_cycles", 32'(rd), 32'd4);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
`else
    chk("t6_read_stuck", 32'(rd), 32'd20);
    chk("t6_read_still_high", 32'(bus.avm_read), 32'd1);
    chk("t6_timeout_err", 32'(timeout_err), 32'd0);
`endif
    chk("t6_count_unchanged", 32'(poll_count), 32'(c0));
    wr = 1'b0;
    wait_poll("t6");
    chk("t6_status", 32'(status), 32'h3C3);
`ifdef UART1_POLL_TIMEOUT_EN
    chk("t6_timeout_sticky", 32'(timeout_err), 32'd1);
`endif

    // Disable during READ: transaction completes, then IDLE.
    slave_val = 10'h001;
    wait_read("t7");
    enable = 1'b0;
    wait_poll("t7");
    chk("t7_status", 32'(status), 32'h001);
    chk("t7_status_valid_cleared", 32'(status_valid), 32'd0);
    c0 = poll_count;
    tick(3);
    chk("t7_idle_no_read", 32'(bus.avm_read), 32'd0);
    chk("t7_status_held", 32'(status), 32'h001);
    chk("t7_count_held", 32'(poll_count), 32'(c0));
    chk("t7_events_held", 32'(event_bits), 32'h200);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
